uart_note_seq: RTL and testbench

- Playback controller behind the UART byte receiver.
- Accepts each received byte (data plus one-cycle ack strobe), buffers it in a small FIFO, decodes it as a note command and sequences playback.
- Each note is held for a beat-timed duration followed by a fixed articulation gap.
- Drives the tone generator with a note index, octave and note_on; one reserved byte value acts as an immediate stop/flush command.

---
 rtl/uart_note_seq.sv | 178 +++++++++++++++++
 tb/tb_uart_note_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_note_seq.sv
// Note playback sequencer: buffers received command bytes and plays them
// as timed notes (LOAD + PLAY + GAP per slot) toward the tone generator.
module uart_note_seq #(
    parameter int unsigned BEAT_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_ack,
    output logic [3:0]              note_idx,
    output logic [1:0]              octave,
    output logic                    note_on,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(8 * BEAT_TICKS);
    localparam logic [7:0]  STOP_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_next;
    logic [AW:0]   rd_ptr_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    head;
    logic [31:0]   play_len;
    logic          empty;
    logic          full;
    logic          stop;
    logic          pop;
    logic          wr;
    logic          drop;

    // FIFO status and command decode
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        stop     = rx_ack && (rx_data == STOP_BYTE);
        head     = mem[rd_ptr[AW-1:0]];
        // PLAY cycles of the slot: whole slot minus the LOAD cycle and the gap
        play_len = (32'(BEAT_TICKS) << head[1:0]) - 32'(GAP_TICKS) - 32'd1;
    end

    // Next-state logic; the counter holds the PLAY cycles left (including the current one) or GAP cycles left minus one
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                pop = 1'b1;
                if (play_len == 32'd0) begin
                    state_next = GAP;
                    cnt_next   = CW'(GAP_TICKS - 1);
                end else begin
                    state_next = PLAY;
                    cnt_next   = CW'(play_len);
                end
            end
            PLAY: begin
                if (cnt == CW'(1)) begin
                    state_next = GAP;
                    cnt_next   = CW'(GAP_TICKS - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = empty ? IDLE : LOAD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // STOP overrides everything, including a pop in LOAD
        if (stop) begin
            state_next = IDLE;
            cnt_next   = cnt;
            pop        = 1'b0;
        end
    end

    // FIFO write/drop decision and next pointers; a pop frees a slot for a same-edge write
    always_comb begin
        wr          = rx_ack && !stop && (!full || pop);
        drop        = rx_ack && !stop && full && !pop;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (stop) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (wr) begin
                wr_ptr_next = wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    // State, counter, pointers and FIFO status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            fifo_count <= wr_ptr_next - rd_ptr_next;
            if (stop) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Tone generator outputs; note_on follows PLAY one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_idx <= '0;
            octave   <= '0;
            note_on  <= 1'b0;
            busy     <= 1'b0;
        end else if (stop) begin
            note_idx <= '0;
            note_on  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            note_on <= (state == PLAY) && (note_idx != 4'd0);
            busy    <= (state_next != IDLE);
            if (state == LOAD) begin
                note_idx <= head[7] ? 4'd0 : head[7:4];
                octave   <= head[3:2];
            end else if (state_next == IDLE) begin
                note_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_note_seq.sv
// Directed bench for uart_note_seq with BEAT_TICKS=10, GAP_TICKS=2, DEPTH=8.
module tb_uart_note_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ack = 1'b0;
    logic [3:0] note_idx;
    logic [1:0] octave;
    logic       note_on;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_note_seq #(
        .BEAT_TICKS (10),
        .GAP_TICKS  (2),
        .DEPTH      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ack     (rx_ack),
        .note_idx   (note_idx),
        .octave     (octave),
        .note_on    (note_on),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Output monitor: samples 2 time units after each rising edge; mon_cyc=k means "after edge Ek"
    int         mon_cyc = 0;
    int         busy_cyc = 0;
    int         busy_falls = 0;
    int         on_cyc = 0;
    int         idx_nz = 0;
    int         run_len = 0;
    int         rise_q[$];
    int         onlen_q[$];
    logic [7:0] note_q[$];
    logic       prev_on = 1'b0;
    logic       prev_busy = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (note_on && !prev_on) begin
            rise_q.push_back(mon_cyc);
            note_q.push_back({note_idx, octave, 2'b00});
            run_len = 0;
        end
        if (note_on) begin
            run_len++;
            on_cyc++;
        end
        if (!note_on && prev_on) onlen_q.push_back(run_len);
        if (busy) busy_cyc++;
        if (!busy && prev_busy) busy_falls++;
        if (note_idx != 4'd0) idx_nz++;
        prev_on   = note_on;
        prev_busy = busy;
        mon_cyc++;
    end

    task automatic clear_mon();
        mon_cyc    = 0;
        busy_cyc   = 0;
        busy_falls = 0;
        on_cyc     = 0;
        idx_nz     = 0;
        rise_q.delete();
        onlen_q.delete();
        note_q.delete();
    endtask

    // Present one byte for exactly one rising edge (called at a falling edge)
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_ack  = 1'b1;
        @(negedge clk);
        rx_ack  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (note_idx !== 4'd0) begin n_fail++; $display("FAIL reset_note_idx got=%0h exp=0", note_idx); end
        n_checks++; if (octave !== 2'd0) begin n_fail++; $display("FAIL reset_octave got=%0h exp=0", octave); end
        n_checks++; if (note_on !== 1'b0) begin n_fail++; $display("FAIL reset_note_on got=%b exp=0", note_on); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // 0x14: do, octave 1, one beat -> 7 cycles on, slot of 10
    task automatic test_single_note();
        clear_mon();
        send(8'h14);
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count_after_write got=%0d exp=1", fifo_count); end
        repeat (20) @(negedge clk);
        n_checks++; if (rise_q.size() !== 1 || rise_q[0] !== 3) begin n_fail++; $display("FAIL single_latency rises=%0d first=%0d exp=1 at 3", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1); end
        n_checks++; if (onlen_q.size() !== 1 || onlen_q[0] !== 7) begin n_fail++; $display("FAIL single_on_len got=%0d exp=7", (onlen_q.size() > 0) ? onlen_q[0] : -1); end
        n_checks++; if (note_q.size() !== 1 || note_q[0] !== 8'h14) begin n_fail++; $display("FAIL single_note got=%0h exp=14", (note_q.size() > 0) ? note_q[0] : 8'h00); end
        n_checks++; if (busy_cyc !== 10 || busy_falls !== 1) begin n_fail++; $display("FAIL single_busy cycles=%0d falls=%0d exp=10/1", busy_cyc, busy_falls); end
        n_checks++; if (note_idx !== 4'd0 || octave !== 2'd1) begin n_fail++; $display("FAIL single_idle_outputs idx=%0d oct=%0d exp=0/1", note_idx, octave); end
    endtask

    // Duration codes 0..3 back-to-back: slots 10/20/40/80, contiguous
    task automatic test_duration_sweep();
        int exp_rise [4] = '{3, 13, 33, 73};
        int exp_len  [4] = '{7, 17, 37, 77};
        clear_mon();
        send(8'h20);
        send(8'h21);
        send(8'h22);
        send(8'h23);
        repeat (170) @(negedge clk);
        n_checks++; if (rise_q.size() !== 4 || onlen_q.size() !== 4) begin n_fail++; $display("FAIL sweep_slots rises=%0d lens=%0d exp=4", rise_q.size(), onlen_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rise_q.size() && i < onlen_q.size()) begin
                n_checks++; if (rise_q[i] !== exp_rise[i] || onlen_q[i] !== exp_len[i]) begin n_fail++; $display("FAIL sweep_slot%0d rise=%0d len=%0d exp=%0d/%0d", i, rise_q[i], onlen_q[i], exp_rise[i], exp_len[i]); end
            end
        end
        n_checks++; if (busy_cyc !== 150 || busy_falls !== 1) begin n_fail++; $display("FAIL sweep_busy cycles=%0d falls=%0d exp=150/1", busy_cyc, busy_falls); end
    endtask

    // Ten bytes into an 8-deep FIFO during a long note: last two dropped
    task automatic test_overflow();
        logic [7:0] burst [10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h14, 8'h24, 8'h34};
        logic [7:0] exp_notes [9] = '{8'h30, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h14};
        clear_mon();
        send(8'h33);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) send(burst[i]);
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        repeat (170) @(negedge clk);
        n_checks++; if (note_q.size() !== 9) begin n_fail++; $display("FAIL ovf_played got=%0d exp=9", note_q.size()); end
        for (int i = 0; i < 9; i++) begin
            if (i < note_q.size()) begin
                n_checks++; if (note_q[i] !== exp_notes[i]) begin n_fail++; $display("FAIL ovf_note%0d got=%0h exp=%0h", i, note_q[i], exp_notes[i]); end
            end
        end
        n_checks++; if (busy !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end busy=%b ovf=%b exp=0/1", busy, overflow); end
    endtask

    // STOP at edge 20 of an 8-beat note with two bytes queued (overflow still set)
    task automatic test_stop();
        clear_mon();
        send(8'h33);
        send(8'h41);
        send(8'h52);
        repeat (17) @(negedge clk);
        n_checks++; if (note_on !== 1'b1 || fifo_count !== 4'd2 || overflow !== 1'b1) begin n_fail++; $display("FAIL stop_pre on=%b cnt=%0d ovf=%b exp=1/2/1", note_on, fifo_count, overflow); end
        send(8'hFF);
        n_checks++; if (note_on !== 1'b0 || note_idx !== 4'd0) begin n_fail++; $display("FAIL stop_note on=%b idx=%0d exp=0/0", note_on, note_idx); end
        n_checks++; if (fifo_count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_state cnt=%0d ovf=%b busy=%b exp=0/0/0", fifo_count, overflow, busy); end
        clear_mon();
        repeat (30) @(negedge clk);
        n_checks++; if (busy_cyc !== 0 || on_cyc !== 0) begin n_fail++; $display("FAIL stop_silent busy=%0d on=%0d exp=0/0", busy_cyc, on_cyc); end
    endtask

    // Index 0 (2 beats) and reserved index 9 (1 beat) are silent slots
    task automatic test_rest_reserved();
        clear_mon();
        send(8'h05);
        send(8'h94);
        repeat (40) @(negedge clk);
        n_checks++; if (on_cyc !== 0 || idx_nz !== 0) begin n_fail++; $display("FAIL rest_silent on=%0d idx_nz=%0d exp=0/0", on_cyc, idx_nz); end
        n_checks++; if (busy_cyc !== 30 || busy_falls !== 1) begin n_fail++; $display("FAIL rest_busy cycles=%0d falls=%0d exp=30/1", busy_cyc, busy_falls); end
        n_checks++; if (octave !== 2'd1) begin n_fail++; $display("FAIL rest_octave got=%0d exp=1", octave); end
    endtask

    // Reset asserted between clock edges mid-PLAY with three bytes buffered
    task automatic test_async_reset();
        send(8'h33);
        send(8'h41);
        send(8'h52);
        send(8'h63);
        repeat (3) @(negedge clk);
        n_checks++; if (note_on !== 1'b1 || fifo_count !== 4'd3) begin n_fail++; $display("FAIL areset_pre on=%b cnt=%0d exp=1/3", note_on, fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (note_on !== 1'b0 || busy !== 1'b0 || note_idx !== 4'd0) begin n_fail++; $display("FAIL areset_outputs on=%b busy=%b idx=%0d exp=0/0/0", note_on, busy, note_idx); end
        n_checks++; if (fifo_count !== 4'd0 || octave !== 2'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL areset_status cnt=%0d oct=%0d ovf=%b exp=0/0/0", fifo_count, octave, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (30) @(negedge clk);
        n_checks++; if (busy_cyc !== 0 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL areset_no_replay busy=%0d cnt=%0d exp=0/0", busy_cyc, fifo_count); end
        clear_mon();
        send(8'h71);
        repeat (30) @(negedge clk);
        n_checks++; if (note_q.size() !== 1 || note_q[0] !== 8'h70 || busy_cyc !== 20) begin n_fail++; $display("FAIL areset_new_note n=%0d busy=%0d exp=1 note 70 busy 20", note_q.size(), busy_cyc); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_duration_sweep();
        test_overflow();
        test_stop();
        test_rest_reserved();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
